// File: rtl/hmmm_muldiv.sv
// Iterative signed multiply / divide / modulo unit for the HMMM core.
// Fixed latency: WIDTH iterations plus one sign-fix cycle, for every op and operand.
module hmmm_muldiv #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [PW-1:0] LIM = PW'(1) << (WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_MOD = 2'b10;

   logic [1:0]       state, state_nx;
   logic [CW-1:0]    cnt;
   logic [1:0]       op_q;
   logic             sa, neg, bz;
   logic [WIDTH-1:0] mag_op;   // |a| for mul (multiplicand), |b| for div/mod (divisor)
   logic [WIDTH:0]   acc;      // product high half / partial remainder
   logic [WIDTH-1:0] mq;       // multiplier -> product low half / dividend -> quotient

   logic             accept_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [WIDTH:0]   acc_nx_c, acc_add_c, shifted_c;
   logic [WIDTH+1:0] diff_c;
   logic [WIDTH-1:0] mq_nx_c;
   logic [PW-1:0]    prod_c;
   logic [WIDTH-1:0] fix_result_c;
   logic             fix_dbz_c, fix_ovf_c;

   assign accept_c = start && (state == S_IDLE || state == S_DONE);
   assign a_mag_c  = a[WIDTH-1] ? WIDTH'(-a) : a;
   assign b_mag_c  = b[WIDTH-1] ? WIDTH'(-b) : b;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
         S_FIX:   state_nx = S_DONE;
         S_DONE:  state_nx = start ? S_RUN : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // One shift-add (mul) or restoring-subtract (div/mod) step on the magnitudes
   always_comb begin
      acc_nx_c  = acc;
      mq_nx_c   = mq;
      acc_add_c = '0;
      shifted_c = '0;
      diff_c    = '0;
      if (op_q == OP_MUL) begin
         acc_add_c = mq[0] ? acc + (WIDTH + 1)'(mag_op) : acc;
         acc_nx_c  = acc_add_c >> 1;
         mq_nx_c   = {acc_add_c[0], mq[WIDTH-1:1]};
      end else begin
         shifted_c = {acc[WIDTH-1:0], mq[WIDTH-1]};
         diff_c    = {1'b0, shifted_c} - (WIDTH + 2)'(mag_op);
         if (!diff_c[WIDTH+1]) begin
            acc_nx_c = diff_c[WIDTH:0];
            mq_nx_c  = {mq[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx_c = shifted_c;
            mq_nx_c  = {mq[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Sign correction and flags; low half of a negated product equals the negated low half
   always_comb begin
      prod_c       = {acc[WIDTH-1:0], mq};
      fix_result_c = '0;
      fix_dbz_c    = 1'b0;
      fix_ovf_c    = 1'b0;
      case (op_q)
         OP_MUL: begin
            fix_result_c = neg ? WIDTH'(-mq) : mq;
            fix_ovf_c    = neg ? (prod_c > LIM) : (prod_c >= LIM);
         end
         OP_DIV: begin
            fix_dbz_c = bz;
            if (!bz) begin
               fix_result_c = neg ? WIDTH'(-mq) : mq;
               fix_ovf_c    = !neg && mq[WIDTH-1];
            end
         end
         OP_MOD: begin
            fix_dbz_c = bz;
            if (!bz) fix_result_c = sa ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         op_q   <= '0;
         sa     <= 1'b0;
         neg    <= 1'b0;
         bz     <= 1'b0;
         mag_op <= '0;
         acc    <= '0;
         mq     <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         dbz    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= (state == S_FIX);
         if (accept_c) begin
            cnt    <= '0;
            op_q   <= op;
            sa     <= a[WIDTH-1];
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            bz     <= (b == '0);
            mag_op <= (op == OP_MUL) ? a_mag_c : b_mag_c;
            mq     <= (op == OP_MUL) ? b_mag_c : a_mag_c;
            acc    <= '0;
            busy   <= 1'b1;
         end else if (state == S_RUN) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nx_c;
            mq  <= mq_nx_c;
         end else if (state == S_FIX) begin
            result <= fix_result_c;
            dbz    <= fix_dbz_c;
            ovf    <= fix_ovf_c;
            busy   <= 1'b0;
         end
      end
   end

endmodule
